// File: rtl/and_stage_sequencer.sv
// and_stage_sequencer: buffered valid/ready stage wrapped around an external
// n-bit bitwise AND array. Operand pairs are queued in a DEPTH-entry FIFO.
// The FIFO head drives the array inputs. The array's combinational result is
// registered into a single result slot that has its own valid/ready handshake.
// A wrapping counter reports how many results were accepted downstream.
//
// Optional feature: define AND_STAGE_PARITY_EN to add the res_parity output.
// It carries the XOR reduction of the captured result.
module and_stage_sequencer #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic [N-1:0]     and_a,
    output logic [N-1:0]     and_b,
    input  logic [N-1:0]     and_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_data,
    output logic             res_zero,
`ifdef AND_STAGE_PARITY_EN
    output logic             res_parity,
`endif
    output logic [CNT_W-1:0] op_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW + 1)'(DEPTH);

    // Operand storage. It has no reset: the head is masked to zero while
    // the FIFO is empty, so stale contents are never visible.
    logic [N-1:0]     r_mem_a [DEPTH];
    logic [N-1:0]     r_mem_b [DEPTH];

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic             r_res_valid;
    logic [N-1:0]     r_res_data;
    logic             r_res_zero;
    logic [CNT_W-1:0] r_op_count;
`ifdef AND_STAGE_PARITY_EN
    logic             r_res_parity;
`endif

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_cap;
    logic             w_res_hs;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == OCC_FULL);

    // Registered occupancy is the only input, so there is no path from
    // res_ready. The term with rst_n holds the output low during reset.
    assign in_ready = rst_n & ~w_full;

    assign w_push   = in_valid & in_ready;
    assign w_cap    = ~w_empty & (~r_res_valid | res_ready);
    assign w_res_hs = r_res_valid & res_ready;

    // The head comes straight from storage. A pair that was just pushed
    // spends one full cycle here before it is captured.
    assign and_a = w_empty ? '0 : r_mem_a[r_rptr];
    assign and_b = w_empty ? '0 : r_mem_b[r_rptr];

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_zero  = r_res_zero;
    assign op_count  = r_op_count;
`ifdef AND_STAGE_PARITY_EN
    assign res_parity = r_res_parity;
`endif

    // Each storage entry is written when a push targets its slot.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Write entry gi on a push addressed to it.
            always_ff @(posedge clk) begin
                if (w_push && (r_wptr == AW'(gi))) begin
                    r_mem_a[gi] <= in_a;
                    r_mem_b[gi] <= in_b;
                end
            end
        end
    endgenerate

    // FIFO pointers and occupancy. DEPTH is a power of two, so both
    // pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_cap) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_cap})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Result slot: capture the array output when the slot is free or being
    // drained. Otherwise clear valid on a drain, and keep the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_zero   <= 1'b0;
`ifdef AND_STAGE_PARITY_EN
            r_res_parity <= 1'b0;
`endif
        end else if (w_cap) begin
            r_res_valid  <= 1'b1;
            r_res_data   <= and_out;
            r_res_zero   <= (and_out == '0);
`ifdef AND_STAGE_PARITY_EN
            r_res_parity <= ^and_out;
`endif
        end else if (w_res_hs) begin
            r_res_valid  <= 1'b0;
        end
    end

    // Count the results accepted downstream. The counter wraps at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_res_hs) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

endmodule

// File: doc/and_stage_sequencer.md
Name: and_stage_sequencer

Overview:
- Buffered sequencing stage that sits directly around the n-bit bitwise AND array.
- Accepts operand pairs through a valid/ready handshake and queues them in a small FIFO.
- Drives the FIFO head onto the AND array inputs, then registers the array's combinational result into an output slot with its own valid/ready handshake.
- Provides throughput of one operation per cycle. Supplies a zero flag and a wrapping operation counter for the lab's ALU datapath.

Parameters:
- N, 8, operand and result width in bits.
- DEPTH, 4, operand FIFO depth in entries; power of two, minimum 2.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  FIFO can accept a pair; equals !full.
- in_a  input  N  operand A.
- in_b  input  N  operand B.
- and_a  output  N  A operand to the AND array; FIFO head A, or 0 when empty.
- and_b  output  N  B operand to the AND array; FIFO head B, or 0 when empty.
- and_out  input  N  combinational result returned by the AND array.
- res_valid  output  1  result slot holds a result.
- res_ready  input  1  downstream accepts the result.
- res_data  output  N  registered result.
- res_zero  output  1  high when res_data == 0; qualified by res_valid.
- op_count  output  CNT_W  number of results accepted downstream; wraps.

Behaviour:
- Reset: asynchronous, applies immediately on rst_n low, and is safe mid-operation. It sets:
  - FIFO write/read pointers and occupancy to 0;
  - res_valid=0, res_data=0, res_zero=0, op_count=0;
  - in_ready=1 once reset is released (held at 0 while rst_n is low).
  - All in-flight and queued operands are discarded.
- Push: occurs when in_valid && in_ready at a clk edge. The pair is written at wptr, and wptr wraps modulo DEPTH.
- Head drive: and_a/and_b come straight from the storage registers at rptr and are stable for the whole cycle. Zeros are driven when the FIFO is empty.
- Capture:
  - Condition: cap = !empty && (!res_valid || res_ready).
  - On cap: res_data<=and_out, res_zero<=(and_out==0), res_valid<=1, pop the FIFO, and rptr wraps modulo DEPTH.
- Drain: if res_valid && res_ready && !cap, res_valid<=0. res_data holds its last value.
- op_count increments on every res_valid && res_ready edge. It wraps from 2^CNT_W-1 to 0.
- Latency: a pair accepted at edge t is on and_a/and_b during cycle t+1 and captured at edge t+1. res_valid is high from t+1 when the slot is free.
- Throughput: one result per cycle while res_ready stays high.
- Occupancy: tracked with a DEPTH+1-value counter.
  - Push and pop in the same cycle leaves occupancy unchanged.
  - Full means occupancy==DEPTH; in_ready=0 and no push occurs.
  - A push into an empty FIFO is not forwarded in the same cycle; a pair always spends one cycle at the head.
- Backpressure:
  - With res_valid=1 and res_ready=0, res_data, res_valid and res_zero hold, and no capture occurs.
  - The FIFO fills, and in_ready drops after DEPTH further accepts.
- in_ready depends only on registered occupancy, with no combinational path from res_ready. res_valid/res_data depend only on registers.

Optional Feature:
- Macro: AND_STAGE_PARITY_EN.
- Defined: adds output port res_parity (1 bit).
  - res_parity = XOR reduction of and_out, registered with res_data on cap.
  - Reset value 0; holds under backpressure like res_data.
- Undefined: no res_parity port and no parity logic. All other behaviour is identical.

Test Plan:
- Reset then single op: in_a=8'hF0, in_b=8'h3C, res_ready=1 -> res_valid high from t+1, res_data=8'h30, res_zero=0, op_count=1 after handshake.
- Zero result: in_a=8'hAA, in_b=8'h55 -> res_data=8'h00, res_zero=1. With AND_STAGE_PARITY_EN defined, res_parity=0.
- Backpressure fill (DEPTH=4): hold res_ready=0 and stream 6 pairs -> 1 in result slot plus 4 queued, then in_ready=0. Releasing res_ready drains 5 results in order, one per cycle.
- Streaming: 16 back-to-back pairs with res_ready=1 -> in_ready never drops, 16 consecutive res_valid cycles, op_count=16.
- Counter wrap with CNT_W=4: 17 accepted results -> op_count reads 15 then 0 then 1.
- Reset mid-operation: FIFO holding 3 entries with res_valid=1, assert rst_n=0 asynchronously between edges -> res_valid=0 and op_count=0 immediately, and_a/and_b=0. After release no stale result appears.
